// File: rtl/ehl_wdt_mc_pkg.sv
// Shared definitions for the multi-channel windowed watchdog: FSM encoding,
// register map offsets, kick key and CTRL/STATUS bit positions.
package ehl_wdt_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_WARN    = 2'd2,
        ST_EXPIRED = 2'd3
    } wdt_state_e;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_LOAD   = 3'd1;
    localparam logic [2:0] REG_WINDOW = 3'd2;
    localparam logic [2:0] REG_KICK   = 3'd3;
    localparam logic [2:0] REG_COUNT  = 3'd4;
    localparam logic [2:0] REG_STATUS = 3'd5;

    localparam logic [15:0] KICK_KEY = 16'hA5C3;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_LOCK      = 1;
    localparam int CTRL_IE        = 2;
    localparam int CTRL_PRESC_LSB = 8;

    localparam int STAT_WARN   = 0;
    localparam int STAT_EARLY  = 1;
    localparam int STAT_BADKEY = 2;

endpackage

// File: rtl/ehl_wdt_mc_ch.sv
// One watchdog channel: prescaler, down-counter, IDLE/RUN/WARN/EXPIRED FSM and
// its CTRL/LOAD/WINDOW/STATUS registers. EHL_WDT_MC_LOCK_EN enables CTRL.lock.
module ehl_wdt_mc_ch
    import ehl_wdt_mc_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int PRESC_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_ctrl,
    input  logic             wr_load,
    input  logic             wr_window,
    input  logic             wr_kick,
    input  logic             wr_status,
    input  logic [WIDTH-1:0] wdata,
    input  logic [2:0]       reg_off,
    output logic [WIDTH-1:0] rd_data,
    output logic             irq_ch,
    output logic             rst_ch
);

    wdt_state_e         state_q, state_d;
    logic               en_q, en_d;
    logic               ie_q, ie_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic [WIDTH-1:0]   load_q, load_d;
    logic [WIDTH-1:0]   window_q, window_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               warn_q, warn_d;
    logic               early_q, early_d;
    logic               badkey_q, badkey_d;
    logic               irq_q, irq_d;
    logic               rst_q, rst_d;

    logic               cfg_wr;
    logic               lock_rd;
    logic               ctrl_wr_ok;
    logic               kick_ok;
    logic               kick_bad;
    logic               tick;
    logic [WIDTH-1:0]   reload_val;

`ifdef EHL_WDT_MC_LOCK_EN
    logic lock_q, lock_d;
    assign cfg_wr  = ~lock_q;
    assign lock_rd = lock_q;
`else
    assign cfg_wr  = 1'b1;
    assign lock_rd = 1'b0;
`endif

    assign ctrl_wr_ok = wr_ctrl & cfg_wr;
    assign kick_ok    = wr_kick & (wdata[15:0] == KICK_KEY);
    assign kick_bad   = wr_kick & (wdata[15:0] != KICK_KEY);
    // >= rather than == so a presc lowered mid-count still wraps promptly.
    assign tick       = (pcnt_q >= presc_q);
    assign reload_val = (load_q == '0) ? WIDTH'(1) : load_q;

    // NOTE: every _d gets its _q as default first, so no path leaves a latch.
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        ie_d     = ie_q;
        presc_d  = presc_q;
        pcnt_d   = pcnt_q;
        load_d   = load_q;
        window_d = window_q;
        count_d  = count_q;
        warn_d   = warn_q;
        early_d  = early_q;
        badkey_d = badkey_q;
`ifdef EHL_WDT_MC_LOCK_EN
        lock_d   = lock_q;
`endif

        // Clears first so that any set below in the same cycle wins.
        if (wr_status) begin
            warn_d   = warn_q   & ~wdata[STAT_WARN];
            early_d  = early_q  & ~wdata[STAT_EARLY];
            badkey_d = badkey_q & ~wdata[STAT_BADKEY];
        end
        if (kick_bad) begin
            badkey_d = 1'b1;
        end

        if (ctrl_wr_ok) begin
            en_d    = wdata[CTRL_EN];
            ie_d    = wdata[CTRL_IE];
            presc_d = wdata[CTRL_PRESC_LSB +: PRESC_W];
`ifdef EHL_WDT_MC_LOCK_EN
            lock_d  = lock_q | wdata[CTRL_LOCK];
`endif
        end
        if (wr_load && cfg_wr) begin
            load_d = wdata;
        end
        if (wr_window && cfg_wr) begin
            window_d = wdata;
        end

        unique case (state_q)
            ST_IDLE: begin
                pcnt_d = '0;
                if (ctrl_wr_ok && wdata[CTRL_EN] && !en_q) begin
                    state_d = ST_RUN;
                    count_d = reload_val;
                end
            end
            ST_RUN, ST_WARN: begin
                if (ctrl_wr_ok && !wdata[CTRL_EN]) begin
                    state_d = ST_IDLE;
                end else if (kick_ok) begin
                    pcnt_d = '0;
                    if (state_q == ST_WARN || count_q <= window_q) begin
                        state_d = ST_RUN;
                        count_d = reload_val;
                    end else begin
                        early_d = 1'b1;
                        state_d = ST_EXPIRED;
                    end
                end else if (tick) begin
                    pcnt_d = '0;
                    if (count_q == WIDTH'(1)) begin
                        if (state_q == ST_RUN) begin
                            state_d = ST_WARN;
                            warn_d  = 1'b1;
                            count_d = reload_val;
                        end else begin
                            state_d = ST_EXPIRED;
                        end
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end else begin
                    pcnt_d = pcnt_q + PRESC_W'(1);
                end
            end
            default: begin
            end
        endcase

        irq_d = warn_d & ie_d;
        rst_d = (state_d == ST_EXPIRED);
    end

    // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            en_q     <= 1'b0;
            ie_q     <= 1'b0;
            presc_q  <= '0;
            pcnt_q   <= '0;
            load_q   <= '1;
            window_q <= '1;
            count_q  <= '0;
            warn_q   <= 1'b0;
            early_q  <= 1'b0;
            badkey_q <= 1'b0;
            irq_q    <= 1'b0;
            rst_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            ie_q     <= ie_d;
            presc_q  <= presc_d;
            pcnt_q   <= pcnt_d;
            load_q   <= load_d;
            window_q <= window_d;
            count_q  <= count_d;
            warn_q   <= warn_d;
            early_q  <= early_d;
            badkey_q <= badkey_d;
            irq_q    <= irq_d;
            rst_q    <= rst_d;
        end
    end

`ifdef EHL_WDT_MC_LOCK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`endif

    always_comb begin
        rd_data = '0;
        case (reg_off)
            REG_CTRL: begin
                rd_data[CTRL_EN]                     = en_q;
                rd_data[CTRL_LOCK]                   = lock_rd;
                rd_data[CTRL_IE]                     = ie_q;
                rd_data[CTRL_PRESC_LSB +: PRESC_W]   = presc_q;
            end
            REG_LOAD:   rd_data = load_q;
            REG_WINDOW: rd_data = window_q;
            REG_COUNT:  rd_data = count_q;
            REG_STATUS: begin
                rd_data[STAT_WARN]   = warn_q;
                rd_data[STAT_EARLY]  = early_q;
                rd_data[STAT_BADKEY] = badkey_q;
            end
            default: begin
            end
        endcase
    end

    assign irq_ch = irq_q;
    assign rst_ch = rst_q;

endmodule

// File: rtl/ehl_wdt_mc.sv
// Multi-channel windowed watchdog top: register-bus decode, read mux and
// irq/rst_req reduction. EHL_WDT_MC_LOCK_EN enables the per-channel CTRL.lock.
module ehl_wdt_mc
    import ehl_wdt_mc_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 4,
    parameter  int PRESC_W  = 8,
    localparam int AW       = 3 + $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr,
    input  logic                rd,
    input  logic [AW-1:0]       addr,
    input  logic [WIDTH-1:0]    wdata,
    output logic [WIDTH-1:0]    rdata,
    output logic [CHANNELS-1:0] irq_ch,
    output logic                irq,
    output logic [CHANNELS-1:0] rst_ch,
    output logic                rst_req
);

    localparam int CSW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [2:0]       reg_off;
    logic [CSW-1:0]   ch_sel;
    logic             ch_valid;
    logic [WIDTH-1:0] ch_rdata [CHANNELS];

    assign reg_off = addr[2:0];

    // A single channel has no channel field in the address.
    if (CHANNELS > 1) begin : g_multi
        assign ch_sel   = addr[AW-1:3];
        assign ch_valid = (int'(ch_sel) < CHANNELS);
    end else begin : g_single
        assign ch_sel   = '0;
        assign ch_valid = 1'b1;
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic hit;
        assign hit = wr & ch_valid & (ch_sel == CSW'(g));

        ehl_wdt_mc_ch #(
            .WIDTH   (WIDTH),
            .PRESC_W (PRESC_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .wr_ctrl   (hit && reg_off == REG_CTRL),
            .wr_load   (hit && reg_off == REG_LOAD),
            .wr_window (hit && reg_off == REG_WINDOW),
            .wr_kick   (hit && reg_off == REG_KICK),
            .wr_status (hit && reg_off == REG_STATUS),
            .wdata     (wdata),
            .reg_off   (reg_off),
            .rd_data   (ch_rdata[g]),
            .irq_ch    (irq_ch[g]),
            .rst_ch    (rst_ch[g])
        );
    end

    always_comb begin
        rdata = '0;
        if (rd && ch_valid) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (ch_sel == CSW'(i)) begin
                    rdata = ch_rdata[i];
                end
            end
        end
    end

    assign irq     = |irq_ch;
    assign rst_req = |rst_ch;

endmodule

// File: tb/tb_ehl_wdt_mc.sv
// Self-checking bench for ehl_wdt_mc: directed scenarios plus randomized bus
// traffic compared cycle by cycle against a behavioural watchdog model.
module tb_ehl_wdt_mc;

    localparam int WIDTH    = 32;
    localparam int CHANNELS = 4;
    localparam int PRESC_W  = 8;
    localparam int AW       = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic                wr;
    logic                rd;
    logic [AW-1:0]       addr;
    logic [WIDTH-1:0]    wdata;
    logic [WIDTH-1:0]    rdata;
    logic [CHANNELS-1:0] irq_ch;
    logic                irq;
    logic [CHANNELS-1:0] rst_ch;
    logic                rst_req;

    ehl_wdt_mc #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .PRESC_W  (PRESC_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr      (wr),
        .rd      (rd),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq_ch  (irq_ch),
        .irq     (irq),
        .rst_ch  (rst_ch),
        .rst_req (rst_req)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_RUN, M_WARN, M_EXP} m_st_e;

    m_st_e       m_st      [CHANNELS];
    bit          m_en      [CHANNELS];
    bit          m_ie      [CHANNELS];
    bit          m_lock    [CHANNELS];
    int unsigned m_presc   [CHANNELS];
    bit [31:0]   m_load    [CHANNELS];
    bit [31:0]   m_window  [CHANNELS];
    bit [31:0]   m_count   [CHANNELS];
    bit          m_warn    [CHANNELS];
    bit          m_early   [CHANNELS];
    bit          m_badkey  [CHANNELS];
    int unsigned m_elapsed [CHANNELS];

    task automatic model_reset();
        for (int c = 0; c < CHANNELS; c++) begin
            m_st[c] = M_IDLE; m_en[c] = 0; m_ie[c] = 0; m_lock[c] = 0; m_presc[c] = 0;
            m_load[c] = 32'hFFFF_FFFF; m_window[c] = 32'hFFFF_FFFF; m_count[c] = 0;
            m_warn[c] = 0; m_early[c] = 0; m_badkey[c] = 0; m_elapsed[c] = 0;
        end
    endtask

    // One clock edge of the whole block, given the bus inputs present at that edge.
    task automatic model_step(input bit w, input logic [AW-1:0] a, input logic [31:0] d);
        int ch  = int'(a[AW-1:3]);
        int off = int'(a[2:0]);
        for (int c = 0; c < CHANNELS; c++) begin
            bit hit = w && (ch == c);
            bit cfg_ok = 1;
            bit good_kick, bad_kick, ctrl_w, tick;
            bit [31:0] reload;
`ifdef EHL_WDT_MC_LOCK_EN
            cfg_ok = !m_lock[c];
`endif
            good_kick = hit && off == 3 && d[15:0] == 16'hA5C3;
            bad_kick  = hit && off == 3 && d[15:0] != 16'hA5C3;
            ctrl_w    = hit && off == 0 && cfg_ok;
            reload    = (m_load[c] == 0) ? 32'd1 : m_load[c];
            tick      = ((m_elapsed[c] + 1) % (m_presc[c] + 1)) == 0;

            if (hit && off == 5) begin
                if (d[0]) m_warn[c]   = 0;
                if (d[1]) m_early[c]  = 0;
                if (d[2]) m_badkey[c] = 0;
            end
            if (bad_kick) m_badkey[c] = 1;

            case (m_st[c])
                M_IDLE: begin
                    if (ctrl_w && d[0] && !m_en[c]) begin
                        m_st[c] = M_RUN; m_count[c] = reload; m_elapsed[c] = 0;
                    end
                end
                M_RUN, M_WARN: begin
                    if (ctrl_w && !d[0]) begin
                        m_st[c] = M_IDLE;
                    end else if (good_kick) begin
                        m_elapsed[c] = 0;
                        if (m_st[c] == M_WARN || m_count[c] <= m_window[c]) begin
                            m_st[c] = M_RUN; m_count[c] = reload;
                        end else begin
                            m_early[c] = 1; m_st[c] = M_EXP;
                        end
                    end else begin
                        m_elapsed[c]++;
                        if (tick) begin
                            if (m_count[c] != 1) m_count[c]--;
                            else if (m_st[c] == M_RUN) begin
                                m_st[c] = M_WARN; m_warn[c] = 1; m_count[c] = reload;
                            end else m_st[c] = M_EXP;
                        end
                    end
                end
                default: begin end
            endcase

            if (ctrl_w) begin
                m_en[c] = d[0]; m_ie[c] = d[2]; m_presc[c] = int'(d[15:8]);
`ifdef EHL_WDT_MC_LOCK_EN
                if (d[1]) m_lock[c] = 1;
`endif
            end
            if (hit && off == 1 && cfg_ok) m_load[c]   = d;
            if (hit && off == 2 && cfg_ok) m_window[c] = d;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [AW-1:0] a);
        int ch  = int'(a[AW-1:3]);
        int off = int'(a[2:0]);
        case (off)
            0: return 32'(m_presc[ch] << 8) | {29'd0, m_ie[ch], m_lock[ch], m_en[ch]};
            1: return m_load[ch];
            2: return m_window[ch];
            4: return m_count[ch];
            5: return {29'd0, m_badkey[ch], m_early[ch], m_warn[ch]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_outputs();
        logic [CHANNELS-1:0] e_irq, e_rst;
        for (int c = 0; c < CHANNELS; c++) begin
            e_irq[c] = m_warn[c] & m_ie[c];
            e_rst[c] = (m_st[c] == M_EXP);
        end
        check("irq_ch", 32'(irq_ch), 32'(e_irq));
        check("rst_ch", 32'(rst_ch), 32'(e_rst));
        check("irq", 32'(irq), 32'(|e_irq));
        check("rst_req", 32'(rst_req), 32'(|e_rst));
    endtask

    // ---------------- bus helpers ----------------
    task automatic bus_cycle(input bit w, input bit r, input int ch, input int off,
                             input logic [31:0] d, input bit use_exp,
                             input logic [31:0] exp, input string tag);
        logic [AW-1:0] a;
        a = AW'(ch * 8 + off);
        wr = w; rd = r; addr = a; wdata = d;
        #1;
        if (r) check(tag, rdata, use_exp ? exp : model_read(a));
        else   check("rdata_idle", rdata, 32'd0);
        @(posedge clk);
        model_step(w, a, d);
        #1;
        check_outputs();
        wr = 0; rd = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) bus_cycle(0, 0, 0, 0, 32'd0, 0, 32'd0, "");
    endtask

    task automatic wr_reg(input int ch, input int off, input logic [31:0] d);
        bus_cycle(1, 0, ch, off, d, 0, 32'd0, "");
    endtask

    task automatic rd_mod(input int ch, input int off);
        bus_cycle(0, 1, ch, off, 32'd0, 0, 32'd0, "rd_model");
    endtask

    task automatic rd_exp(input int ch, input int off, input logic [31:0] exp, input string tag);
        bus_cycle(0, 1, ch, off, 32'd0, 1, exp, tag);
    endtask

    task automatic do_reset();
        reset = 1; wr = 0; rd = 0;
        @(posedge clk);
        model_reset();
        #1;
        reset = 0;
        check_outputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int unsigned presc_r [CHANNELS];

    initial begin
        reset = 1; wr = 0; rd = 0; addr = '0; wdata = '0;

        // Reset values
        do_reset();
        rd_exp(0, 0, 32'd0, "rst_ctrl");
        rd_exp(0, 1, 32'hFFFF_FFFF, "rst_load");
        rd_exp(0, 2, 32'hFFFF_FFFF, "rst_window");
        rd_exp(0, 4, 32'd0, "rst_count");
        rd_exp(0, 5, 32'd0, "rst_status");

        // 1: no kick -> warn at 10, expiry at 20
        wr_reg(0, 1, 32'd10);
        wr_reg(0, 0, 32'h5);
        idle(9);
        check("t1_irq_before", 32'(irq_ch), 32'h0);
        idle(1);
        check("t1_irq_at10", 32'(irq_ch), 32'h1);
        check("t1_irq_or", 32'(irq), 32'h1);
        idle(9);
        check("t1_rst_before", 32'(rst_ch), 32'h0);
        idle(1);
        check("t1_rst_at20", 32'(rst_ch), 32'h1);
        check("t1_rst_req", 32'(rst_req), 32'h1);

        // 2: early kick, then in-window kick
        do_reset();
        wr_reg(1, 1, 32'd100);
        wr_reg(1, 2, 32'd20);
        wr_reg(1, 0, 32'h1);
        idle(50);
        wr_reg(1, 3, 32'h0000_A5C3);
        check("t2_rst_early", 32'(rst_ch), 32'h2);
        rd_exp(1, 5, 32'h2, "t2_status_early");
        rd_exp(1, 4, 32'd50, "t2_count_frozen");
        do_reset();
        wr_reg(1, 1, 32'd100);
        wr_reg(1, 2, 32'd20);
        wr_reg(1, 0, 32'h1);
        idle(85);
        wr_reg(1, 3, 32'h0000_A5C3);
        rd_exp(1, 4, 32'd100, "t2_count_reload");
        check("t2_no_rst", 32'(rst_ch), 32'h0);

        // 3: bad key, W1C, kick vs terminal tick
        do_reset();
        wr_reg(2, 1, 32'd8);
        wr_reg(2, 0, 32'h5);
        idle(2);
        wr_reg(2, 3, 32'h0000_1234);
        rd_exp(2, 5, 32'h4, "t3_badkey");
        rd_exp(2, 4, 32'd4, "t3_count_unaffected");
        wr_reg(2, 5, 32'h4);
        rd_exp(2, 5, 32'h0, "t3_w1c");
        wr_reg(2, 3, 32'h0000_A5C3);
        rd_exp(2, 4, 32'd8, "t3_kick_wins");
        rd_exp(2, 5, 32'h0, "t3_no_warn");

        // 4: prescaler and LOAD=0
        do_reset();
        wr_reg(3, 1, 32'd4);
        wr_reg(3, 0, 32'h305);
        idle(15);
        check("t4_presc_before", 32'(irq_ch), 32'h0);
        idle(1);
        check("t4_presc_warn", 32'(irq_ch), 32'h8);
        do_reset();
        wr_reg(3, 1, 32'd0);
        wr_reg(3, 0, 32'h305);
        idle(3);
        check("t4_load0_before", 32'(irq_ch), 32'h0);
        idle(1);
        check("t4_load0_warn", 32'(irq_ch), 32'h8);

        // 5: reset while ch3 WARN and ch0 EXPIRED
        do_reset();
        wr_reg(3, 1, 32'd5);
        wr_reg(3, 0, 32'h5);
        wr_reg(0, 1, 32'd2);
        wr_reg(0, 0, 32'h5);
        idle(4);
        check("t5_pre_rst", 32'(rst_ch), 32'h1);
        check("t5_pre_irq", 32'(irq_ch), 32'h9);
        do_reset();
        check("t5_rst_ch", 32'(rst_ch), 32'h0);
        check("t5_irq_ch", 32'(irq_ch), 32'h0);
        rd_exp(0, 0, 32'd0, "t5_ctrl");
        rd_exp(0, 1, 32'hFFFF_FFFF, "t5_load");
        rd_exp(0, 4, 32'd0, "t5_count");
        rd_exp(3, 5, 32'd0, "t5_status");

        // 6: lock behaviour and unused offsets
        do_reset();
`ifdef EHL_WDT_MC_LOCK_EN
        wr_reg(0, 0, 32'h7);
        wr_reg(0, 0, 32'h0);
        rd_exp(0, 0, 32'h7, "t6_lock_ctrl");
        wr_reg(0, 1, 32'd5);
        rd_exp(0, 1, 32'hFFFF_FFFF, "t6_lock_load");
`else
        wr_reg(0, 0, 32'h6);
        rd_exp(0, 0, 32'h4, "t6_nolock_ctrl");
`endif
        wr_reg(1, 6, 32'hDEAD_BEEF);
        rd_exp(1, 6, 32'd0, "t6_off6");
        rd_exp(1, 7, 32'd0, "t6_off7");
        rd_exp(1, 3, 32'd0, "t6_kick_rd");

        // Randomized traffic against the model
        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
            for (int c = 0; c < CHANNELS; c++) begin
                presc_r[c] = $urandom_range(0, 2);
                wr_reg(c, 1, 32'($urandom_range(1, 10)));
                wr_reg(c, 2, 32'($urandom_range(2, 12)));
                wr_reg(c, 0, 32'(presc_r[c] << 8) | 32'h5);
            end
            for (int k = 0; k < 300; k++) begin
                int ch;
                int op;
                logic [31:0] cw;
                ch = $urandom_range(0, CHANNELS - 1);
                op = $urandom_range(0, 99);
                if (op < 35) idle(1);
                else if (op < 55) wr_reg(ch, 3, ($urandom & 32'hFFFF_0000) | 32'h0000_A5C3);
                else if (op < 58) wr_reg(ch, 3, $urandom);
                else if (op < 64) begin
                    cw = 32'(presc_r[ch] << 8);
                    if ($urandom_range(0, 99) < 80) cw[0] = 1'b1;
                    if ($urandom_range(0, 99) < 3)  cw[1] = 1'b1;
                    cw[2] = 1'($urandom_range(0, 1));
                    wr_reg(ch, 0, cw);
                end
                else if (op < 70) wr_reg(ch, 1, 32'($urandom_range(0, 12)));
                else if (op < 75) wr_reg(ch, 2, 32'($urandom_range(0, 12)));
                else if (op < 80) wr_reg(ch, 5, 32'($urandom_range(0, 7)));
                else if (op < 97) rd_mod(ch, $urandom_range(0, 7));
                else wr_reg(ch, $urandom_range(6, 7), $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
